// File: rtl/core_pkg.sv
// Shared decode definitions for the ID/EX stage: opcode constants, the
// subtract funct7 encoding, the instruction-class enum and its decoder.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  typedef enum logic [3:0] {
    ClsOp,
    ClsOpImm,
    ClsLui,
    ClsAuipc,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJalr,
    ClsJal,
    ClsOther
  } op_class_t;

  function automatic op_class_t decode_class(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OPC_OP:     cls = ClsOp;
      OPC_OP_IMM: cls = ClsOpImm;
      OPC_LUI:    cls = ClsLui;
      OPC_AUIPC:  cls = ClsAuipc;
      OPC_LOAD:   cls = ClsLoad;
      OPC_STORE:  cls = ClsStore;
      OPC_BRANCH: cls = ClsBranch;
      OPC_JALR:   cls = ClsJalr;
      OPC_JAL:    cls = ClsJal;
      default:    cls = ClsOther;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX stage.
//   master: upstream decode / downstream EX view (drives in_*, out_ready)
//   slave : the ID/EX stage itself (drives in_ready, out_valid, alu_*, out_rd)
interface id_ex_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_opcode;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic [RADDR_W-1:0] in_rs1_addr;
  logic [RADDR_W-1:0] in_rs2_addr;
  logic [RADDR_W-1:0] in_rd_addr;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_imm;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [2:0]         alu_funct3;
  logic [6:0]         alu_funct7;
  logic [RADDR_W-1:0] out_rd;
  logic               out_reg_write;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rs1_addr, in_rs2_addr,
    output in_rd_addr, in_rs1_data, in_rs2_data, in_pc, in_imm, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_funct3, alu_funct7, out_rd,
    input  out_reg_write
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1_addr, in_rs2_addr,
    input  in_rd_addr, in_rs1_data, in_rs2_data, in_pc, in_imm, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_funct3, alu_funct7, out_rd,
    output out_reg_write
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Source select for one register operand: x0 reads zero, otherwise MEM result,
// then WB result, then register-file data.
// Macro ID_EX_FORWARD_EN: when undefined there is no bypass and the result is
// always the register-file value (the stage stalls on a pending write instead).
// Ports: rs_addr_i, rf_data_i, mem_/wb_ valid/rd/data inputs, data_o.
module operand_fwd_mux #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0]    rf_data_i,
  input  logic               mem_valid_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]    mem_data_i,
  input  logic               wb_valid_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic [XLEN-1:0]    data_o
);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    data_o = rf_data_i;
    if (rs_addr_i == '0) begin
      data_o = '0;
    end else if (mem_valid_i && (mem_rd_i == rs_addr_i)) begin
      data_o = mem_data_i;
    end else if (wb_valid_i && (wb_rd_i == rs_addr_i)) begin
      data_o = wb_data_i;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_valid_i, mem_rd_i, mem_data_i, wb_valid_i, wb_rd_i, wb_data_i};

  always_comb begin
    data_o = rf_data_i;
    if (rs_addr_i == '0) begin
      data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: selects ALU operands by instruction class, forwards
// MEM/WB results, stalls on load-use hazards and registers a normalised
// funct3/funct7 pair. Single-entry buffer with valid/ready on both sides.
// Ports: clk, reset (sync, active-high), bus (decode in / EX out handshake),
//        flush, fwd_mem_*/fwd_wb_* bypass sources, ex_load_valid/ex_load_rd.
// Macro ID_EX_FORWARD_EN: defined enables bypassing; undefined turns any
// pending MEM/WB write to a used source into a stall.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  id_ex_stage_if.slave       bus,
  input  logic               flush,
  input  logic               fwd_mem_valid,
  input  logic [RADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]    fwd_mem_data,
  input  logic               fwd_wb_valid,
  input  logic [RADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]    fwd_wb_data,
  input  logic               ex_load_valid,
  input  logic [RADDR_W-1:0] ex_load_rd
);

  op_class_t          cls;
  logic               use_rs1, use_rs2, writes;
  logic [XLEN-1:0]    rs1_val, rs2_val;
  logic [XLEN-1:0]    alu_a_d, alu_b_d;
  logic [2:0]         funct3_d;
  logic [6:0]         funct7_d;
  logic               stall, load_use, fwd_stall, capture;

  logic               out_valid_q;
  logic [XLEN-1:0]    alu_a_q, alu_b_q;
  logic [2:0]         funct3_q;
  logic [6:0]         funct7_q;
  logic [RADDR_W-1:0] rd_q;
  logic               reg_write_q;

  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs1_mux (
    .rs_addr_i  (bus.in_rs1_addr),
    .rf_data_i  (bus.in_rs1_data),
    .mem_valid_i(fwd_mem_valid),
    .mem_rd_i   (fwd_mem_rd),
    .mem_data_i (fwd_mem_data),
    .wb_valid_i (fwd_wb_valid),
    .wb_rd_i    (fwd_wb_rd),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rs1_val)
  );

  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs2_mux (
    .rs_addr_i  (bus.in_rs2_addr),
    .rf_data_i  (bus.in_rs2_data),
    .mem_valid_i(fwd_mem_valid),
    .mem_rd_i   (fwd_mem_rd),
    .mem_data_i (fwd_mem_data),
    .wb_valid_i (fwd_wb_valid),
    .wb_rd_i    (fwd_wb_rd),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rs2_val)
  );

  always_comb begin
    cls      = decode_class(bus.in_opcode);
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    writes   = 1'b0;
    alu_a_d  = '0;
    alu_b_d  = '0;
    funct3_d = 3'b000;
    funct7_d = 7'b0;
    unique case (cls)
      ClsOp: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        writes   = 1'b1;
        alu_a_d  = rs1_val;
        alu_b_d  = rs2_val;
        funct3_d = bus.in_funct3;
        funct7_d = bus.in_funct7;
      end
      ClsOpImm: begin
        use_rs1  = 1'b1;
        writes   = 1'b1;
        alu_a_d  = rs1_val;
        alu_b_d  = bus.in_imm;
        funct3_d = bus.in_funct3;
        // Only the right shifts carry an arithmetic/logical select in imm[11:5].
        if (bus.in_funct3 == 3'b101) funct7_d = bus.in_imm[11:5];
      end
      ClsLui: begin
        writes  = 1'b1;
        alu_b_d = bus.in_imm;
      end
      ClsAuipc: begin
        writes  = 1'b1;
        alu_a_d = bus.in_pc;
        alu_b_d = bus.in_imm;
      end
      ClsLoad, ClsJalr: begin
        use_rs1 = 1'b1;
        writes  = 1'b1;
        alu_a_d = rs1_val;
        alu_b_d = bus.in_imm;
      end
      ClsStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alu_a_d = rs1_val;
        alu_b_d = bus.in_imm;
      end
      ClsBranch: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        alu_a_d  = rs1_val;
        alu_b_d  = rs2_val;
        funct7_d = FUNCT7_SUB;
      end
      ClsJal: begin
        writes = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign load_use = ex_load_valid && (ex_load_rd != '0) &&
                    ((use_rs1 && (ex_load_rd == bus.in_rs1_addr)) ||
                     (use_rs2 && (ex_load_rd == bus.in_rs2_addr)));

`ifdef ID_EX_FORWARD_EN
  assign fwd_stall = 1'b0;
`else
  logic rs1_busy, rs2_busy;
  assign rs1_busy = (bus.in_rs1_addr != '0) &&
                    ((fwd_mem_valid && (fwd_mem_rd == bus.in_rs1_addr)) ||
                     (fwd_wb_valid && (fwd_wb_rd == bus.in_rs1_addr)));
  assign rs2_busy = (bus.in_rs2_addr != '0) &&
                    ((fwd_mem_valid && (fwd_mem_rd == bus.in_rs2_addr)) ||
                     (fwd_wb_valid && (fwd_wb_rd == bus.in_rs2_addr)));
  assign fwd_stall = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);
`endif

  assign stall        = load_use || fwd_stall;
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !stall && !flush;
  assign capture      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      rd_q        <= bus.in_rd_addr;
      reg_write_q <= writes && (bus.in_rd_addr != '0);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_funct3    = funct3_q;
  assign bus.alu_funct7    = funct7_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import core_pkg::*;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, pc, imm;
    logic [31:0] ea, eb;
    logic [2:0]  ef3;
    logic [6:0]  ef7;
    logic        erw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fwd_mem_valid = 1'b0, fwd_wb_valid = 1'b0, ex_load_valid = 1'b0;
  logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0, ex_load_rd = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;

  int checks = 0;
  int errors = 0;
  vec_t sb_q[$];

  id_ex_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flush        (flush),
    .fwd_mem_valid(fwd_mem_valid),
    .fwd_mem_rd   (fwd_mem_rd),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_valid (fwd_wb_valid),
    .fwd_wb_rd    (fwd_wb_rd),
    .fwd_wb_data  (fwd_wb_data),
    .ex_load_valid(ex_load_valid),
    .ex_load_rd   (ex_load_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [2:0] ef3, input logic [6:0] ef7, input logic erw);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.d1 = d1; v.d2 = d2; v.pc = pc; v.imm = imm;
    v.ea = ea; v.eb = eb; v.ef3 = ef3; v.ef7 = ef7; v.erw = erw;
    return v;
  endfunction

  task automatic present(input vec_t v);
    bus.in_opcode   = v.opc;
    bus.in_funct3   = v.f3;
    bus.in_funct7   = v.f7;
    bus.in_rs1_addr = v.rs1;
    bus.in_rs2_addr = v.rs2;
    bus.in_rd_addr  = v.rd;
    bus.in_rs1_data = v.d1;
    bus.in_rs2_data = v.d2;
    bus.in_pc       = v.pc;
    bus.in_imm      = v.imm;
    bus.in_valid    = 1'b1;
  endtask

  // Offer v until accepted; expected result enters the scoreboard on acceptance.
  task automatic send(input vec_t v, output int waits);
    bit done = 0;
    present(v);
    waits = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(v);
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          errors++;
          checks++;
          $display("FAIL send_timeout: in_ready stuck at 0 for opcode 0x%02h", v.opc);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_alu_a"}, bus.alu_a, 32'd0);
    check({tag, "_alu_b"}, bus.alu_b, 32'd0);
    check({tag, "_funct3"}, 32'(bus.alu_funct3), 32'd0);
    check({tag, "_funct7"}, 32'(bus.alu_funct7), 32'd0);
    check({tag, "_out_rd"}, 32'(bus.out_rd), 32'd0);
    check({tag, "_reg_write"}, 32'(bus.out_reg_write), 32'd0);
  endtask

  // Monitor: every transfer to EX is compared against the oldest expectation.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("alu_a", bus.alu_a, e.ea);
          check("alu_b", bus.alu_b, e.eb);
          check("alu_funct3", 32'(bus.alu_funct3), 32'(e.ef3));
          check("alu_funct7", 32'(bus.alu_funct7), 32'(e.ef7));
          check("out_rd", 32'(bus.out_rd), 32'(e.rd));
          check("out_reg_write", 32'(bus.out_reg_write), 32'(e.erw));
        end
      end
    end
  end

  initial begin
    int w;
    vec_t vb;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    present(mk(7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;

    // Operand selection per class
    send(mk(OPC_OP, 3'b000, 7'h00, 1, 2, 5, 5, 7, 0, 0, 5, 7, 3'b000, 7'h00, 1), w);
    check("add_no_wait", 32'(w), 0);
    send(mk(OPC_OP_IMM, 3'b101, 7'h20, 1, 5, 6, 32'h8000_0000, 32'h99, 0, 32'h405,
            32'h8000_0000, 32'h405, 3'b101, 7'h20, 1), w);
    send(mk(OPC_OP_IMM, 3'b000, 7'h40, 1, 0, 0, 10, 0, 0, 32'hFFFF_F800,
            10, 32'hFFFF_F800, 3'b000, 7'h00, 0), w);
    send(mk(OPC_STORE, 3'b010, 7'h00, 1, 2, 5, 20, 30, 0, 8, 20, 8, 3'b000, 7'h00, 0), w);
    send(mk(OPC_BRANCH, 3'b001, 7'h00, 1, 2, 11, 20, 30, 0, 16, 20, 30, 3'b000, 7'h20, 0), w);
    send(mk(OPC_AUIPC, 3'b111, 7'h00, 9, 9, 12, 3, 4, 32'h1000, 32'h2000,
            32'h1000, 32'h2000, 3'b000, 7'h00, 1), w);
    send(mk(7'b0001111, 3'b001, 7'h7F, 1, 2, 3, 20, 30, 32'h40, 32'h7,
            0, 0, 3'b000, 7'h00, 0), w);

    // Forwarding: MEM over WB over register file
    fwd_mem_valid = 1'b1; fwd_mem_rd = 3; fwd_mem_data = 32'hAA;
    fwd_wb_valid = 1'b1;  fwd_wb_rd = 3;  fwd_wb_data = 32'hBB;
`ifdef ID_EX_FORWARD_EN
    send(mk(OPC_OP_IMM, 3'b000, 7'h00, 3, 0, 8, 32'h11, 0, 0, 1,
            32'hAA, 1, 3'b000, 7'h00, 1), w);
    check("fwd_mem_no_wait", 32'(w), 0);
    fwd_mem_valid = 1'b0;
    send(mk(OPC_OP_IMM, 3'b000, 7'h00, 3, 0, 8, 32'h11, 0, 0, 1,
            32'hBB, 1, 3'b000, 7'h00, 1), w);
    check("fwd_wb_no_wait", 32'(w), 0);
    fwd_wb_valid = 1'b0;
`else
    present(mk(OPC_OP_IMM, 3'b000, 7'h00, 3, 0, 8, 32'h11, 0, 0, 1, 0, 0, 0, 0, 0));
    repeat (2) begin
      @(negedge clk);
      check("nofwd_mem_stall", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 fwd_mem_valid = 1'b0;
    @(negedge clk);
    check("nofwd_wb_stall", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 fwd_wb_valid = 1'b0;
    send(mk(OPC_OP_IMM, 3'b000, 7'h00, 3, 0, 8, 32'h11, 0, 0, 1,
            32'h11, 1, 3'b000, 7'h00, 1), w);
    check("nofwd_release", 32'(w), 0);
`endif
    fwd_mem_valid = 1'b1; fwd_mem_rd = 0; fwd_mem_data = 32'hCC;
    send(mk(OPC_OP_IMM, 3'b000, 7'h00, 0, 0, 13, 32'h55, 0, 0, 3,
            0, 3, 3'b000, 7'h00, 1), w);
    check("x0_no_wait", 32'(w), 0);
    fwd_mem_valid = 1'b0;

    // Load-use hazard on rs2
    ex_load_valid = 1'b1; ex_load_rd = 4;
    vb = mk(OPC_OP, 3'b000, 7'h20, 1, 4, 9, 3, 9, 0, 0, 3, 9, 3'b000, 7'h20, 1);
    present(vb);
    repeat (3) begin
      @(negedge clk);
      check("load_use_stall", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    ex_load_valid = 1'b0;
    send(vb, w);
    check("load_use_release", 32'(w), 0);
    ex_load_valid = 1'b1;
    send(mk(OPC_LUI, 3'b000, 7'h00, 4, 4, 14, 32'h77, 32'h88, 0, 32'h1234_5000,
            0, 32'h1234_5000, 3'b000, 7'h00, 1), w);
    check("lui_no_stall", 32'(w), 0);
    ex_load_valid = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure, then back-to-back transfer
    bus.out_ready = 1'b0;
    send(mk(OPC_OP, 3'b000, 7'h00, 1, 2, 10, 5, 7, 0, 0, 5, 7, 3'b000, 7'h00, 1), w);
    vb = mk(OPC_OP, 3'b110, 7'h00, 1, 2, 15, 32'hF0, 32'h0F, 0, 0,
            32'hF0, 32'h0F, 3'b110, 7'h00, 1);
    present(vb);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_alu_a_hold", bus.alu_a, 5);
      check("bp_alu_b_hold", bus.alu_b, 7);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(vb, w);
    check("b2b_no_wait", 32'(w), 0);
    @(negedge clk);
    check("b2b_no_bubble", 32'(bus.out_valid), 1);
    @(posedge clk);
    #1;

    // Flush kills held and incoming instruction
    bus.out_ready = 1'b0;
    send(mk(OPC_OP, 3'b000, 7'h00, 1, 2, 16, 1, 2, 0, 0, 1, 2, 3'b000, 7'h00, 1), w);
    present(mk(OPC_OP, 3'b000, 7'h00, 1, 2, 17, 3, 4, 0, 0, 0, 0, 0, 0, 0));
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 0);
    sb_q.delete();
    @(posedge clk);
    #1;

    // Reset while holding an entry
    send(mk(OPC_OP, 3'b000, 7'h00, 1, 2, 18, 9, 9, 0, 0, 9, 9, 3'b000, 7'h00, 1), w);
    check("hold_before_reset", 32'(bus.out_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    sb_q.delete();
    @(posedge clk);
    #1;

    // Final transfer then drain
    bus.out_ready = 1'b1;
    send(mk(OPC_JALR, 3'b000, 7'h00, 1, 0, 1, 32'h100, 0, 0, 4,
            32'h100, 4, 3'b000, 7'h00, 1), w);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
